// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed seven-segment digit scanner with tear-free frame swap.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [6*NUM_DIGITS-1:0] in_data,
  output logic                    in_ready,
  output logic [5:0]              binary,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = 6 * NUM_DIGITS;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] disp_q, disp_d;
  logic [FW-1:0] pend_q, pend_d;
  logic          pflag_q, pflag_d;
  logic          tick;
  logic          last;
  logic [5:0]    code;

  assign tick        = (cnt_q == CW'(PRESCALE - 1));
  assign last        = (idx_q == IW'(NUM_DIGITS - 1));
  assign frame_start = tick & last;
  assign in_ready    = ~pflag_q;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = last ? '0 : idx_q + 1'b1;
    end
    // Swap only at the frame boundary so the display never tears.
    if (frame_start && pflag_q) begin
      disp_d  = pend_q;
      pflag_d = 1'b0;
    end else if (in_valid && !pflag_q) begin
      pend_d  = in_data;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= {NUM_DIGITS{6'd63}};
      pend_q  <= '0;
      pflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
    end
  end

  assign digit_en = NUM_DIGITS'(1) << idx_q;
  assign code     = disp_q[6*idx_q +: 6];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  hz;

  // Walk down from the MSD; a digit blanks while everything above is zero.
  always_comb begin
    hz    = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hz       = hz && (disp_q[6*i +: 6] == 6'd0);
      blank[i] = hz;
    end
  end

  assign binary = blank[idx_q] ? 6'd63 : code;
`else
  assign binary = code;
`endif

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: randomized and directed checks of digit_scan against a
// cycle-count based reference model (NUM_DIGITS=4, PRESCALE=4).
module tb_digit_scan;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int FP = N * P;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [6*N-1:0] in_data = '0;
  logic          in_ready;
  logic [5:0]    binary;
  logic [N-1:0]  digit_en;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  int         t;
  logic [5:0] m_disp [N];
  logic [5:0] m_pend [N];
  bit         m_pflag;
  logic [11:0] ev;

  digit_scan #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .binary(binary), .digit_en(digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_vec();
    int idx = (t / P) % N;
    int top = -1;
    logic fs = ((t % FP) == FP - 1);
    logic [5:0] b;
    for (int i = 0; i < N; i++) if (m_disp[i] != 6'd0) top = i;
    b = m_disp[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx >= 1 && idx > top) b = 6'd63;
`endif
    return {4'(1 << idx), b, fs, ~m_pflag};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {digit_en, binary, frame_start, in_ready};
  endfunction

  task automatic model_reset();
    t = 0;
    m_pflag = 1'b0;
    for (int i = 0; i < N; i++) m_disp[i] = 6'd63;
  endtask

  task automatic model_adv();
    if (rst) begin
      model_reset();
    end else begin
      if (((t % FP) == FP - 1) && m_pflag) begin
        for (int i = 0; i < N; i++) m_disp[i] = m_pend[i];
        m_pflag = 1'b0;
      end else if (in_valid && !m_pflag) begin
        for (int i = 0; i < N; i++) m_pend[i] = in_data[6*i +: 6];
        m_pflag = 1'b1;
      end
      t++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (digit_en !== 4'b0001) begin
      errors++; $display("FAIL rst_en got %b exp 0001", digit_en);
    end
    checks++;
    if (binary !== 6'd63) begin
      errors++; $display("FAIL rst_bin got %0d exp 63", binary);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_rdy got %b exp 1", in_ready);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL rst_fs got %b exp 0", frame_start);
    end
  endtask

  task automatic test_idle_scan();
    apply_reset();
    for (int c = 0; c < 34; c++) begin
      in_valid = 1'b0;
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL idle t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c == 15 || c == 31) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++; $display("FAIL idle_fs c=%0d got %b exp 1", c, frame_start);
        end
      end
      model_adv();
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      in_valid = (c == 2);
      in_data  = {6'd3, 6'd2, 6'd1, 6'd0};
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL load t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL load_busy got %b exp 0", in_ready);
        end
      end
      if (c == 16 || c == 20 || c == 24 || c == 28) begin
        checks++;
        if (binary !== 6'((c - 16) / 4) || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_show c=%0d got %0d/%b exp %0d/1", c, binary, in_ready, (c - 16) / 4);
        end
      end
      model_adv();
      @(negedge clk);
    end
  endtask

  task automatic test_hold_busy();
    bit gotb = 1'b0;
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      in_valid = (c == 2) || (c >= 3 && !gotb);
      if (c == 2) in_data = {6'd3, 6'd2, 6'd1, 6'd0};
      else in_data = m_pflag ? 24'($urandom) : {6'd9, 6'd8, 6'd7, 6'd6};
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL hold t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c == 16 || c == 17) begin
        checks++;
        if (in_ready !== (c == 16)) begin
          errors++; $display("FAIL hold_rdy c=%0d got %b exp %b", c, in_ready, c == 16);
        end
      end
      if (c >= 3 && in_valid && !m_pflag) gotb = 1'b1;
      model_adv();
      @(negedge clk);
    end
  endtask

  task automatic test_fs_handshake();
    apply_reset();
    for (int c = 0; c < 50; c++) begin
      in_valid = (c == 15);
      in_data  = {6'd4, 6'd5, 6'd6, 6'd7};
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL fshs t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c == 16 || c == 32) begin
        checks++;
        if (binary !== ((c == 16) ? 6'd63 : 6'd7)) begin
          errors++; $display("FAIL fshs_show c=%0d got %0d", c, binary);
        end
      end
      model_adv();
      @(negedge clk);
    end
  endtask

  task automatic test_blank();
`ifdef LEADING_ZERO_BLANK_EN
    logic [5:0] ea [8] = '{6'd0, 6'd7, 6'd63, 6'd63, 6'd0, 6'd63, 6'd63, 6'd63};
`else
    logic [5:0] ea [8] = '{6'd0, 6'd7, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
`endif
    apply_reset();
    for (int c = 0; c < 48; c++) begin
      in_valid = (c == 0) || (c == 16);
      in_data  = (c == 0) ? {6'd0, 6'd0, 6'd7, 6'd0} : '0;
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL blank t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c >= 16 && (c % 4) == 0) begin
        checks++;
        if (binary !== ea[(c - 16) / 4]) begin
          errors++;
          $display("FAIL blank_dig c=%0d got %0d exp %0d", c, binary, ea[(c - 16) / 4]);
        end
      end
      model_adv();
      @(negedge clk);
    end
  endtask

  task automatic test_midreset();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      rst      = (c == 8);
      in_valid = (c == 1);
      in_data  = {6'd1, 6'd2, 6'd3, 6'd4};
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL mrst t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      if (c == 9) begin
        checks++;
        if (binary !== 6'd63 || in_ready !== 1'b1 || digit_en !== 4'b0001) begin
          errors++;
          $display("FAIL mrst_state got %0d/%b/%b exp 63/1/0001", binary, in_ready, digit_en);
        end
      end
      model_adv();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        in_data[6*i +: 6] = (r < 4) ? 6'd0 :
                            (r < 8) ? 6'($urandom_range(1, 9)) :
                                      6'($urandom_range(10, 63));
      end
      ev = exp_vec();
      checks++;
      if (obs_vec() !== ev) begin
        errors++; $display("FAIL rand t=%0d got %h exp %h", t, obs_vec(), ev);
      end
      model_adv();
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_scan();
    test_load();
    test_hold_busy();
    test_fs_handshake();
    test_blank();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
